adder_arbiter: RTL and testbench
================================

Name: adder_arbiter

Overview:
Shares a single adder_16bit instance between NUM_REQ requesters using round-robin arbitration and valid/ready handshakes. The block accepts one operand set, executes it on the shared adder and holds the tagged result until the consumer takes it. It sits between ALU-side clients and the adder datapath, so the adder is not replicated per client.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
ID_W, 2, requester-index width; must equal $clog2(NUM_REQ). Checked at elaboration.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
req_valid  input  NUM_REQ  bit i: requester i presents an operation.
req_a  input  16*NUM_REQ  operand a; slice i is bits [16*i+15:16*i].
req_b  input  16*NUM_REQ  operand b; same slicing as req_a.
req_cin  input  NUM_REQ  carry-in per requester.
req_ready  output  NUM_REQ  one-hot accept strobe; combinational, asserted only in IDLE.
res_valid  output  1  result available.
res_ready  input  1  consumer accepts the result.
res_sum  output  16  registered sum.
res_cout  output  1  registered carry-out.
res_id  output  ID_W  index of the requester that owns the result.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Encoding is a localparam in the package.
- IDLE: if any req_valid bit is set, grant g = first set bit searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - req_ready[g] is 1 in the same cycle and the handshake completes.
  - At the clock edge, latch op_a, op_b, op_cin and op_id from slice g, set last_grant=g and go to EXEC.
  - If no bit is set, stay in IDLE with req_ready all zero.
- EXEC: the adder is fed only from the latched op_* registers. Its outputs are registered into res_sum/res_cout, res_id is set to op_id, and the FSM goes to RESP. No input is sampled in this state.
- RESP: res_valid=1. Sum, cout and id stay stable while res_ready=0.
  - On res_ready=1, go to IDLE; res_valid drops the next cycle.
  - No new request is accepted in the RESP cycle itself. This is deliberate so req_ready stays independent of res_ready.
- Latency: accept at cycle N, res_valid high at cycle N+2. Peak throughput is one operation per 3 cycles.
- Arithmetic: {res_cout,res_sum} = op_a + op_b + op_cin, modulo 2^17. 0xFFFF+0xFFFF+1 gives sum 0xFFFF, cout 1.
- A requester may drop req_valid before it is granted without consequence; the arbiter does not latch requests.
- Requester operands must be stable only during the accept cycle.
- Reset: applies at any time, including mid-EXEC or mid-RESP, and the in-flight operation is discarded.
  - State=IDLE, last_grant=NUM_REQ-1 (so requester 0 has first priority).
  - res_valid=0, res_sum=0, res_cout=0, res_id=0, busy=0, req_ready=0.
  - op_* registers=0.
- Fairness: a continuously asserting requester waits at most NUM_REQ-1 grants.

Optional Feature:
ADDER_ARB_OVF_EN
- Defined: adds output port res_ovf (1 bit), the registered two's-complement signed overflow of the same add.
  - Equals (op_a[15]==op_b[15]) && (res_sum[15]!=op_a[15]); op_cin participates in the sum.
  - res_ovf resets to 0 and is held in RESP like res_sum.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package adder_arbiter_pkg holds:
  - the FSM state encoding localparams (IDLE=2'd0, EXEC=2'd1, RESP=2'd2);
  - the constant DATA_W=16;
  - a function rr_pick(req, last) that returns the next grant index.
- One natural sub-module, rr_arbiter: combinational round-robin grant from req_valid and last_grant, producing a one-hot grant plus an index.
- adder_16bit is instantiated unchanged as the datapath.

Test Plan:
- Reset then req_valid=0001, req0 a=465 b=987 cin=1, res_ready=1 -> req_ready=0001 at cycle N; res_valid at N+2 with sum=1453, cout=0, id=0.
- req3 only, a=356 b=74 cin=0 -> sum=430, cout=0, id=3; busy high N+1..N+2.
- req_valid=1111 held, res_ready=1 -> grant order 0,1,2,3,0; one accept every 3 cycles.
- req1 a=0xFFFF b=0x0001 cin=0, res_ready=0 for 5 cycles -> sum=0x0000, cout=1, held stable; no req_ready while held; IDLE one cycle after res_ready=1.
- Assert rst during EXEC -> all outputs zero, next grant goes to req0, and no stale result appears.
- With ADDER_ARB_OVF_EN: a=0x7FFF b=0x0001 cin=0 -> sum=0x8000, ovf=1, cout=0; a=0x8000 b=0xFFFF -> sum=0x7FFF, ovf=1, cout=1.

Source files
------------

// File: rtl/adder_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_arbiter_pkg
// Description : Shared definitions for the adder arbiter. Contains the FSM
//               state encoding, the datapath width and the round-robin
//               pick function used by rr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_arbiter_pkg;

   localparam int DATA_W = 16;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE,
      ST_EXEC = EXEC,
      ST_RESP = RESP
   } state_t;

   // Returns the first set bit of req searching upward from last+1 and
   // wrapping modulo num. With no bit set the previous owner is returned;
   // callers qualify the result with |req.
   function automatic int unsigned rr_pick(input logic [7:0]  req,
                                           input int unsigned last,
                                           input int unsigned num);
      int unsigned pick;
      int unsigned idx;
      logic        found;
      pick  = last;
      idx   = 0;
      found = 1'b0;
      for (int unsigned k = 1; k <= 8; k++) begin
         if (!found && (k <= num)) begin
            idx = (last + k) % num;
            if (|(req & (8'd1 << idx))) begin
               pick  = idx;
               found = 1'b1;
            end
         end
      end
      return pick;
   endfunction

endpackage
`default_nettype wire

// File: rtl/adder_16bit.sv
`default_nettype none
// ============================================================================
// Module      : adder_16bit
// Description : 16-bit ripple adder with carry in/out.
//               Ports: a, b (16) operands; cin carry-in;
//                      sum (16) result; cout carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'd0, cin};

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin grant. Searches req upward from
//               last_grant+1 with wraparound.
//               Ports: req (NUM_REQ) requests; last_grant (ID_W) previous
//                      owner; grant (NUM_REQ) one-hot grant; grant_id (ID_W)
//                      granted index; any_req high when any request is set.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
   import adder_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last_grant,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id,
   output logic               any_req
);

   logic [7:0] w_req8;

   always_comb begin
      w_req8                = '0;
      w_req8[NUM_REQ-1:0]   = req;
      any_req               = |req;
      grant_id              = ID_W'(rr_pick(w_req8, 32'(last_grant), NUM_REQ));
      grant                 = any_req ? (NUM_REQ'(1) << grant_id) : '0;
   end

endmodule
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : adder_arbiter
// Description : Shares one adder_16bit between NUM_REQ requesters using
//               round-robin arbitration and valid/ready handshakes. One
//               operation is accepted, executed and held as a tagged result
//               until the consumer takes it.
//               Ports: clk, rst (async active-high);
//                      req_valid/req_cin (NUM_REQ), req_a/req_b (16*NUM_REQ)
//                      requester side; req_ready (NUM_REQ) one-hot accept;
//                      res_valid, res_ready, res_sum (16), res_cout,
//                      res_id (ID_W) result side; busy when not idle.
//               Build option: ADDER_ARB_OVF_EN adds res_ovf, the registered
//               signed overflow of the add.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_arbiter
   import adder_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [DATA_W*NUM_REQ-1:0] req_a,
   input  logic [DATA_W*NUM_REQ-1:0] req_b,
   input  logic [NUM_REQ-1:0]        req_cin,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [DATA_W-1:0]         res_sum,
   output logic                      res_cout,
   output logic [ID_W-1:0]           res_id,
`ifdef ADDER_ARB_OVF_EN
   output logic                      res_ovf,
`endif
   output logic                      busy
);

   generate
      if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
         $error("adder_arbiter: ID_W must equal $clog2(NUM_REQ)");
      end
      if ((NUM_REQ < 2) || (NUM_REQ > 8)) begin : g_bad_num_req
         $error("adder_arbiter: NUM_REQ must be in 2..8");
      end
   endgenerate

   state_t              r_state;
   state_t              w_state_next;

   logic [ID_W-1:0]     r_last_grant;
   logic [NUM_REQ-1:0]  w_grant;
   logic [ID_W-1:0]     w_grant_id;
   logic                w_any_req;
   logic                w_accept;

   logic [DATA_W-1:0]   w_sel_a;
   logic [DATA_W-1:0]   w_sel_b;
   logic                w_sel_cin;

   logic [DATA_W-1:0]   r_op_a;
   logic [DATA_W-1:0]   r_op_b;
   logic                r_op_cin;
   logic [ID_W-1:0]     r_op_id;

   logic [DATA_W-1:0]   w_add_sum;
   logic                w_add_cout;

   logic [DATA_W-1:0]   r_res_sum;
   logic                r_res_cout;
   logic [ID_W-1:0]     r_res_id;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arbiter (
      .req        (req_valid),
      .last_grant (r_last_grant),
      .grant      (w_grant),
      .grant_id   (w_grant_id),
      .any_req    (w_any_req)
   );

   // The adder only ever sees the latched operands, so requesters may change
   // their inputs freely once the accept cycle has passed.
   adder_16bit u_adder (
      .a    (r_op_a),
      .b    (r_op_b),
      .cin  (r_op_cin),
      .sum  (w_add_sum),
      .cout (w_add_cout)
   );

   // Operand mux for the granted slice.
   always_comb begin
      w_sel_a   = '0;
      w_sel_b   = '0;
      w_sel_cin = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (ID_W'(i) == w_grant_id) begin
            w_sel_a   = req_a[i*DATA_W +: DATA_W];
            w_sel_b   = req_b[i*DATA_W +: DATA_W];
            w_sel_cin = req_cin[i];
         end
      end
   end

   // Accept is suppressed while reset is asserted so no handshake can
   // complete against a block that is about to discard it.
   assign w_accept  = (r_state == ST_IDLE) && w_any_req && !rst;
   assign req_ready = w_accept ? w_grant : '0;
   assign res_valid = (r_state == ST_RESP);
   assign busy      = (r_state != ST_IDLE);
   assign res_sum   = r_res_sum;
   assign res_cout  = r_res_cout;
   assign res_id    = r_res_id;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // RESP never accepts a new request so req_ready does not depend on
   // res_ready.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_any_req) w_state_next = ST_EXEC;
         ST_EXEC: w_state_next = ST_RESP;
         ST_RESP: if (res_ready) w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_grant <= ID_W'(NUM_REQ - 1);
         r_op_a       <= '0;
         r_op_b       <= '0;
         r_op_cin     <= 1'b0;
         r_op_id      <= '0;
         r_res_sum    <= '0;
         r_res_cout   <= 1'b0;
         r_res_id     <= '0;
      end else begin
         if (w_accept) begin
            r_op_a       <= w_sel_a;
            r_op_b       <= w_sel_b;
            r_op_cin     <= w_sel_cin;
            r_op_id      <= w_grant_id;
            r_last_grant <= w_grant_id;
         end
         if (r_state == ST_EXEC) begin
            r_res_sum  <= w_add_sum;
            r_res_cout <= w_add_cout;
            r_res_id   <= r_op_id;
         end
      end
   end

`ifdef ADDER_ARB_OVF_EN
   logic r_res_ovf;

   // Signed overflow: like-signed operands producing a differently-signed sum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_res_ovf <= 1'b0;
      end else if (r_state == ST_EXEC) begin
         r_res_ovf <= (r_op_a[DATA_W-1] == r_op_b[DATA_W-1]) &&
                      (w_add_sum[DATA_W-1] != r_op_a[DATA_W-1]);
      end
   end

   assign res_ovf = r_res_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_arbiter
// Description : Self-checking bench for adder_arbiter (NUM_REQ=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_arbiter;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req_valid;
   logic [16*N-1:0] req_a;
   logic [16*N-1:0] req_b;
   logic [N-1:0]  req_cin;
   logic [N-1:0]  req_ready;
   logic          res_valid;
   logic          res_ready;
   logic [15:0]   res_sum;
   logic          res_cout;
   logic [1:0]    res_id;
   logic          busy;
`ifdef ADDER_ARB_OVF_EN
   logic          res_ovf;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   adder_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .req_ready (req_ready),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_cout  (res_cout),
      .res_id    (res_id),
`ifdef ADDER_ARB_OVF_EN
      .res_ovf   (res_ovf),
`endif
      .busy      (busy)
   );

   typedef struct {
      logic [3:0]  valid;
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [1:0]  id;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int r, input logic [15:0] a, input logic [15:0] b, input logic cin);
      req_a[r*16 +: 16] = a;
      req_b[r*16 +: 16] = b;
      req_cin[r]        = cin;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{4'b0001, 16'd465,   16'd987,   1'b1, 2'd0, 16'd1453,  1'b0, 1'b0};
      vecs[1] = '{4'b1000, 16'd356,   16'd74,    1'b0, 2'd3, 16'd430,   1'b0, 1'b0};
      vecs[2] = '{4'b0100, 16'hFFFF,  16'hFFFF,  1'b1, 2'd2, 16'hFFFF,  1'b1, 1'b0};
      vecs[3] = '{4'b0010, 16'h1234,  16'h4321,  1'b0, 2'd1, 16'h5555,  1'b0, 1'b0};
      vecs[4] = '{4'b0001, 16'h8000,  16'h8000,  1'b0, 2'd0, 16'h0000,  1'b1, 1'b1};
      vecs[5] = '{4'b0001, 16'h7FFF,  16'h0001,  1'b0, 2'd0, 16'h8000,  1'b0, 1'b1};
      vecs[6] = '{4'b1000, 16'h8000,  16'hFFFF,  1'b0, 2'd3, 16'h7FFF,  1'b1, 1'b1};

      rst       = 1'b1;
      req_valid = 4'b1111;
      req_a     = '0;
      req_b     = '0;
      req_cin   = '0;
      res_ready = 1'b1;
      repeat (2) tick();

      // Reset state, including no accept while reset is held.
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_sum",       32'(res_sum),   32'd0);
      chk("rst_cout",      32'(res_cout),  32'd0);
      chk("rst_id",        32'(res_id),    32'd0);
`ifdef ADDER_ARB_OVF_EN
      chk("rst_ovf",       32'(res_ovf),   32'd0);
`endif
      req_valid = '0;
      rst       = 1'b0;
      tick();

      // Single-requester vectors; operands are scrambled after accept.
      for (int i = 0; i < 7; i++) begin
         req_valid = vecs[i].valid;
         set_op(int'(vecs[i].id), vecs[i].a, vecs[i].b, vecs[i].cin);
         #1;
         chk("vec_req_ready", 32'(req_ready), 32'(vecs[i].valid));
         chk("vec_idle_busy", 32'(busy),      32'd0);
         tick();
         req_valid = '0;
         req_a     = {4{16'hA5A5}};
         req_b     = {4{16'h5A5A}};
         req_cin   = 4'b1111;
         #1;
         chk("vec_exec_busy",  32'(busy),      32'd1);
         chk("vec_exec_valid", 32'(res_valid), 32'd0);
         tick();
         chk("vec_res_valid", 32'(res_valid), 32'd1);
         chk("vec_sum",       32'(res_sum),   32'(vecs[i].sum));
         chk("vec_cout",      32'(res_cout),  32'(vecs[i].cout));
         chk("vec_id",        32'(res_id),    32'(vecs[i].id));
`ifdef ADDER_ARB_OVF_EN
         chk("vec_ovf",       32'(res_ovf),   32'(vecs[i].ovf));
`endif
         tick();
         chk("vec_done_valid", 32'(res_valid), 32'd0);
         chk("vec_done_busy",  32'(busy),      32'd0);
      end

      // Round robin with all requesters held: order 0,1,2,3,0.
      rst = 1'b1;
      #1;
      rst = 1'b0;
      #1;
      for (int r = 0; r < N; r++)
         set_op(r, 16'(r*100 + 1), 16'd7, r[0]);
      req_valid = 4'b1111;
      #1;
      for (int k = 0; k < 5; k++) begin
         int g;
         g = k % N;
         chk("rr_grant", 32'(req_ready), 32'(1 << g));
         tick();
         chk("rr_exec_ready", 32'(req_ready), 32'd0);
         tick();
         chk("rr_resp_ready", 32'(req_ready), 32'd0);
         chk("rr_id",         32'(res_id),    32'(g));
         chk("rr_sum",        32'(res_sum),   32'(g*100 + 8 + (g % 2)));
         tick();
      end
      req_valid = '0;
      tick();

      // Result held while the consumer stalls.
      res_ready = 1'b0;
      req_valid = 4'b0010;
      set_op(1, 16'hFFFF, 16'h0001, 1'b0);
      #1;
      chk("hold_grant", 32'(req_ready), 32'b0010);
      tick();
      req_a = '1;
      tick();
      for (int c = 0; c < 5; c++) begin
         chk("hold_valid", 32'(res_valid), 32'd1);
         chk("hold_sum",   32'(res_sum),   32'h0000);
         chk("hold_cout",  32'(res_cout),  32'd1);
         chk("hold_id",    32'(res_id),    32'd1);
         chk("hold_ready", 32'(req_ready), 32'd0);
         tick();
      end
      res_ready = 1'b1;
      #1;
      chk("hold_release_valid", 32'(res_valid), 32'd1);
      tick();
      chk("hold_idle_busy",  32'(busy),      32'd0);
      chk("hold_idle_valid", 32'(res_valid), 32'd0);
      req_valid = '0;
      tick();

      // Reset during EXEC discards the in-flight operation.
      req_valid = 4'b0100;
      set_op(2, 16'h1111, 16'h2222, 1'b0);
      tick();
      req_valid = '0;
      chk("mid_exec_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(res_valid), 32'd0);
      chk("mid_rst_busy",  32'(busy),      32'd0);
      chk("mid_rst_sum",   32'(res_sum),   32'd0);
      chk("mid_rst_id",    32'(res_id),    32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_no_stale", 32'(res_valid), 32'd0);
      req_valid = 4'b1111;
      set_op(0, 16'd5, 16'd6, 1'b0);
      #1;
      chk("post_rst_grant", 32'(req_ready), 32'b0001);
      tick();
      req_valid = '0;
      tick();
      chk("post_rst_valid", 32'(res_valid), 32'd1);
      chk("post_rst_sum",   32'(res_sum),   32'd11);
      chk("post_rst_id",    32'(res_id),    32'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
